// File: rtl/sprite_compositor_pkg.sv
// Shared definitions for the sprite compositor: default widths, colour key,
// sprite register field layout and the derived width helpers.
// Sprite register layout, MSB to LSB: {en, anim, frame, y, x}.
package sprite_compositor_pkg;

  localparam int          DEF_COORD_W = 10;
  localparam int          DEF_COLOR_W = 12;
  localparam logic [11:0] DEF_KEY     = 12'h00f;

  // ROM address width: one row of SPR_W pixels per frame, frames side by side
  function automatic int calc_aw(input int spr_w, input int spr_h, input int frames);
    return $clog2(spr_w * spr_h * frames);
  endfunction

  // Sprite register width: en + anim + frame index + y + x
  function automatic int calc_dw(input int frames, input int coord_w);
    return 2 + $clog2(frames) + 2 * coord_w;
  endfunction

  // Field offsets inside a sprite register
  function automatic int fld_x_lsb();
    return 0;
  endfunction

  function automatic int fld_y_lsb(input int coord_w);
    return coord_w;
  endfunction

  function automatic int fld_frame_lsb(input int coord_w);
    return 2 * coord_w;
  endfunction

  function automatic int fld_anim_bit(input int frames, input int coord_w);
    return 2 * coord_w + $clog2(frames);
  endfunction

  function automatic int fld_en_bit(input int frames, input int coord_w);
    return 2 * coord_w + $clog2(frames) + 1;
  endfunction

  // Index width for a select over n items; never zero
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: active register, window test and ROM address generation.
// Latency: inwin_o/rom_addr_o registered one cycle after the pixel coordinate.
// No backpressure; a new pixel is accepted every cycle.
module sprite_channel
  import sprite_compositor_pkg::*;
#(
  parameter int SPR_W   = 16,
  parameter int SPR_H   = 16,
  parameter int FRAMES  = 4,
  parameter int COORD_W = DEF_COORD_W,
  localparam int FB     = $clog2(FRAMES),
  localparam int AW     = calc_aw(SPR_W, SPR_H, FRAMES),
  localparam int DW     = calc_dw(FRAMES, COORD_W)
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               commit_i,
  input  logic [DW-1:0]      commit_dat_i,
  input  logic               pix_vld_i,
  input  logic [COORD_W-1:0] pix_x_i,
  input  logic [COORD_W-1:0] pix_y_i,
  input  logic [FB-1:0]      anim_frame_i,
  output logic               inwin_o,
  output logic [AW-1:0]      rom_addr_o
);

  logic [DW-1:0]      active_q, active_d;
  logic               inwin_q, inwin_d;
  logic [AW-1:0]      addr_q, addr_d;

  logic               spr_en, spr_anim;
  logic [FB-1:0]      spr_frame, eff_frame;
  logic [COORD_W-1:0] spr_x, spr_y;
  logic [COORD_W:0]   dx, dy;
  logic               dx_ok, dy_ok;

  assign spr_x     = active_q[fld_x_lsb() +: COORD_W];
  assign spr_y     = active_q[fld_y_lsb(COORD_W) +: COORD_W];
  assign spr_frame = active_q[fld_frame_lsb(COORD_W) +: FB];
  assign spr_anim  = active_q[fld_anim_bit(FRAMES, COORD_W)];
  assign spr_en    = active_q[fld_en_bit(FRAMES, COORD_W)];

  // One extra bit keeps the difference signed, so a sprite near the right or
  // bottom edge never produces a hit on pixels wrapped round to coordinate 0.
  assign dx = {1'b0, pix_x_i} - {1'b0, spr_x};
  assign dy = {1'b0, pix_y_i} - {1'b0, spr_y};

  assign dx_ok = !dx[COORD_W] && (dx[COORD_W-1:0] < COORD_W'(SPR_W));
  assign dy_ok = !dy[COORD_W] && (dy[COORD_W-1:0] < COORD_W'(SPR_H));

  // FRAMES is a power of two, so the FB-bit add wraps modulo FRAMES for free
  assign eff_frame = spr_anim ? (spr_frame + anim_frame_i) : spr_frame;

  // Active register reloads from the committed shadow value at frame start
  always_comb begin
    active_d = active_q;
    if (commit_i) begin
      active_d = commit_dat_i;
    end
  end

  // Window test and address; address is forced to 0 outside the window
  always_comb begin
    inwin_d = spr_en && pix_vld_i && dx_ok && dy_ok;
    addr_d  = '0;
    if (inwin_d) begin
      addr_d = AW'(dy[COORD_W-1:0]) * AW'(SPR_W * FRAMES)
             + AW'(eff_frame) * AW'(SPR_W)
             + AW'(dx[COORD_W-1:0]);
    end
  end

  // Active register and first pipeline stage
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      active_q <= '0;
      inwin_q  <= 1'b0;
      addr_q   <= '0;
    end else begin
      active_q <= active_d;
      inwin_q  <= inwin_d;
      addr_q   <= addr_d;
    end
  end

  assign inwin_o    = inwin_q;
  assign rom_addr_o = addr_q;

endmodule

// File: rtl/sprite_compositor.sv
// N-channel sprite layer: shadow registers, animation, priority mux, collision.
// Latency: rgb_out/rgb_valid/hit_mask 2 cycles after pix_x/pix_y; rom_addr 1 cycle.
// No backpressure; one pixel per cycle, outputs are never stalled.
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int               N_SPR       = 4,
  parameter int               SPR_W       = 16,
  parameter int               SPR_H       = 16,
  parameter int               FRAMES      = 4,
  parameter int               ANIM_PERIOD = 8,
  parameter int               COORD_W     = DEF_COORD_W,
  parameter int               COLOR_W     = DEF_COLOR_W,
  parameter logic [COLOR_W-1:0] KEY       = COLOR_W'(DEF_KEY),
  localparam int              AW          = calc_aw(SPR_W, SPR_H, FRAMES),
  localparam int              DW          = calc_dw(FRAMES, COORD_W),
  localparam int              IW          = idx_w(N_SPR)
) (
  input  logic                       clk,
  input  logic                       clrn,
  input  logic                       pix_valid,
  input  logic [COORD_W-1:0]         pix_x,
  input  logic [COORD_W-1:0]         pix_y,
  input  logic [COLOR_W-1:0]         bg_color,
  input  logic                       frame_start,
  input  logic                       wr_en,
  input  logic [IW-1:0]              wr_idx,
  input  logic [DW-1:0]              wr_data,
  output logic [N_SPR*AW-1:0]        rom_addr,
  input  logic [N_SPR*COLOR_W-1:0]   rom_data,
  output logic [COLOR_W-1:0]         rgb_out,
  output logic                       rgb_valid,
  output logic [N_SPR-1:0]           hit_mask,
  output logic                       collision
);

  localparam int FB = $clog2(FRAMES);
  localparam int CW = idx_w(ANIM_PERIOD);

  logic [DW-1:0]      shadow_q [N_SPR];
  logic [DW-1:0]      shadow_d [N_SPR];
  logic [DW-1:0]      commit_dat [N_SPR];
  logic [N_SPR-1:0]   wr_sel;

  logic [CW-1:0]      anim_cnt_q, anim_cnt_d;
  logic [FB-1:0]      anim_frame_q, anim_frame_d;

  logic [N_SPR-1:0]   inwin;
  logic               pv1_q;
  logic [COLOR_W-1:0] bg1_q;

  logic [N_SPR-1:0]   opaque;
  logic               multi_hit;
  logic [COLOR_W-1:0] rgb_d, rgb_q;
  logic [N_SPR-1:0]   hit_q;
  logic               vld_q;

  logic               acc_q, acc_d;
  logic               coll_q, coll_d;

  // Per-channel write select, write-through commit value and channel instance.
  // An out-of-range wr_idx matches no channel, so the write is dropped.
  for (genvar g = 0; g < N_SPR; g++) begin : g_chan
    assign wr_sel[g]     = wr_en && (wr_idx == IW'(g));
    assign commit_dat[g] = wr_sel[g] ? wr_data : shadow_q[g];

    sprite_channel #(
      .SPR_W   (SPR_W),
      .SPR_H   (SPR_H),
      .FRAMES  (FRAMES),
      .COORD_W (COORD_W)
    ) u_chan (
      .clk          (clk),
      .clrn         (clrn),
      .commit_i     (frame_start),
      .commit_dat_i (commit_dat[g]),
      .pix_vld_i    (pix_valid),
      .pix_x_i      (pix_x),
      .pix_y_i      (pix_y),
      .anim_frame_i (anim_frame_q),
      .inwin_o      (inwin[g]),
      .rom_addr_o   (rom_addr[g*AW +: AW])
    );
  end

  // Shadow register writes from the host side
  always_comb begin
    for (int i = 0; i < N_SPR; i++) begin
      shadow_d[i] = shadow_q[i];
      if (wr_sel[i]) begin
        shadow_d[i] = wr_data;
      end
    end
  end

  // Animation sequencing: advance one step every ANIM_PERIOD frame starts
  always_comb begin
    anim_cnt_d   = anim_cnt_q;
    anim_frame_d = anim_frame_q;
    if (frame_start) begin
      if (anim_cnt_q == CW'(ANIM_PERIOD - 1)) begin
        anim_cnt_d   = '0;
        anim_frame_d = anim_frame_q + FB'(1);
      end else begin
        anim_cnt_d   = anim_cnt_q + CW'(1);
      end
    end
  end

  // Transparency test on the ROM colour returned for each channel
  always_comb begin
    opaque = '0;
    for (int i = 0; i < N_SPR; i++) begin
      opaque[i] = inwin[i] && (rom_data[i*COLOR_W +: COLOR_W] != KEY);
    end
  end

  // Fixed priority mux: scanning down to index 0 lets the lowest index win
  always_comb begin
    rgb_d = pv1_q ? bg1_q : '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        rgb_d = rom_data[i*COLOR_W +: COLOR_W];
      end
    end
  end

  assign multi_hit = $countones(opaque) > 1;

  // Collision accumulator; the hit seen in the frame_start cycle still counts
  always_comb begin
    acc_d  = acc_q | multi_hit;
    coll_d = coll_q;
    if (frame_start) begin
      coll_d = acc_q | multi_hit;
      acc_d  = 1'b0;
    end
  end

  // Control state: shadow registers, animation counters, collision
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < N_SPR; i++) begin
        shadow_q[i] <= '0;
      end
      anim_cnt_q   <= '0;
      anim_frame_q <= '0;
      acc_q        <= 1'b0;
      coll_q       <= 1'b0;
    end else begin
      for (int i = 0; i < N_SPR; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      anim_cnt_q   <= anim_cnt_d;
      anim_frame_q <= anim_frame_d;
      acc_q        <= acc_d;
      coll_q       <= coll_d;
    end
  end

  // Pixel pipeline: stage 1 carries valid/background, stage 2 the outputs
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      pv1_q <= 1'b0;
      bg1_q <= '0;
      rgb_q <= '0;
      hit_q <= '0;
      vld_q <= 1'b0;
    end else begin
      pv1_q <= pix_valid;
      bg1_q <= bg_color;
      rgb_q <= rgb_d;
      hit_q <= opaque;
      vld_q <= pv1_q;
    end
  end

  assign rgb_out   = rgb_q;
  assign rgb_valid = vld_q;
  assign hit_mask  = hit_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor: directed scenarios plus randomized traffic,
// all outputs compared against a coordinate-arithmetic reference model.
module tb_sprite_compositor;

  localparam int          N    = 4;
  localparam int          SW   = 16;
  localparam int          SH   = 16;
  localparam int          FR   = 4;
  localparam int          AP   = 8;
  localparam int          AW   = 10;
  localparam int          COL  = 12;
  localparam logic [11:0] KEYC = 12'h00f;
  localparam logic [11:0] BGC  = 12'h0a0;

  logic              clk = 1'b0;
  logic              clrn = 1'b1;
  logic              pix_valid = 1'b0;
  logic [9:0]        pix_x = '0;
  logic [9:0]        pix_y = '0;
  logic [11:0]       bg_color = '0;
  logic              frame_start = 1'b0;
  logic              wr_en = 1'b0;
  logic [1:0]        wr_idx = '0;
  logic [23:0]       wr_data = '0;
  logic [N*AW-1:0]   rom_addr;
  logic [N*COL-1:0]  rom_data;
  logic [11:0]       rgb_out;
  logic              rgb_valid;
  logic [N-1:0]      hit_mask;
  logic              collision;

  logic [11:0]       rom_mem [N][1024];

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  logic [23:0] m_shadow [N];
  logic [23:0] m_active [N];
  int          m_cnt, m_af;
  bit          m_acc, m_coll;
  bit          p_vld, p_multi;
  logic [11:0] p_rgb;
  logic [N-1:0] p_hit;
  int          c_addr [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_rom
    assign rom_data[g*COL +: COL] = rom_mem[g][rom_addr[g*AW +: AW]];
  end

  sprite_compositor dut (
    .clk         (clk),
    .clrn        (clrn),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .bg_color    (bg_color),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .rgb_out     (rgb_out),
    .rgb_valid   (rgb_valid),
    .hit_mask    (hit_mask),
    .collision   (collision)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [23:0] spr(input bit en, input bit an, input int fr,
                                      input int y, input int x);
    logic [1:0] f2;
    logic [9:0] y10, x10;
    f2 = fr[1:0]; y10 = y[9:0]; x10 = x[9:0];
    return {en, an, f2, y10, x10};
  endfunction

  task automatic fill_rom(input int ch, input logic [11:0] c);
    for (int a = 0; a < 1024; a++) rom_mem[ch][a] = c;
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_cnt = 0; m_af = 0; m_acc = 0; m_coll = 0;
    p_vld = 0; p_multi = 0; p_rgb = '0; p_hit = '0;
  endtask

  // One pixel clock: drive inputs, advance the model, compare all outputs
  task automatic cyc(input bit pv, input int x, input int y, input logic [11:0] bg,
                     input bit fs, input bit we = 0, input int idx = 0,
                     input logic [23:0] wd = '0);
    logic [11:0]  c_rgb;
    logic [N-1:0] c_hit;
    bit           c_multi, found, inw, an, en;
    int           sx, sy, fr, dx, dy, f;
    logic [23:0]  r;
    pix_valid = pv; pix_x = x[9:0]; pix_y = y[9:0]; bg_color = bg;
    frame_start = fs; wr_en = we; wr_idx = idx[1:0]; wr_data = wd;
    @(posedge clk);
    #1;
    // expected result of the pixel presented in this cycle
    c_rgb = pv ? bg : 12'h000;
    c_hit = '0;
    found = 0;
    for (int i = 0; i < N; i++) begin
      r  = m_active[i];
      sx = int'(r[9:0]); sy = int'(r[19:10]); fr = int'(r[21:20]);
      an = r[22]; en = r[23];
      dx = x - sx; dy = y - sy;
      f  = an ? (m_af + fr) % FR : fr;
      inw = en && pv && dx >= 0 && dx < SW && dy >= 0 && dy < SH;
      c_addr[i] = inw ? dy * SW * FR + f * SW + dx : 0;
      if (inw && rom_mem[i][c_addr[i]] != KEYC) begin
        c_hit[i] = 1'b1;
        if (!found) begin
          c_rgb = rom_mem[i][c_addr[i]];
          found = 1;
        end
      end
    end
    c_multi = $countones(c_hit) >= 2;
    // collision from the pixel now at the compositing stage
    if (fs) begin
      m_coll = m_acc | p_multi;
      m_acc  = 0;
    end else begin
      m_acc = m_acc | p_multi;
    end
    // register commit, host write, animation
    if (fs) for (int i = 0; i < N; i++) m_active[i] = (we && idx == i) ? wd : m_shadow[i];
    if (we && idx >= 0 && idx < N) m_shadow[idx] = wd;
    if (fs) begin
      if (m_cnt == AP - 1) begin
        m_cnt = 0;
        m_af  = (m_af + 1) % FR;
      end else begin
        m_cnt++;
      end
    end
    check("rgb_out", rgb_out, p_rgb);
    check("hit_mask", hit_mask, p_hit);
    check("rgb_valid", rgb_valid, p_vld);
    for (int i = 0; i < N; i++) check($sformatf("rom_addr%0d", i), rom_addr[i*AW +: AW], c_addr[i]);
    check("collision", collision, m_coll);
    p_rgb = c_rgb; p_hit = c_hit; p_vld = pv; p_multi = c_multi;
    @(negedge clk);
  endtask

  task automatic frame_pulse();
    cyc(0, 0, 0, 12'h000, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, 0, BGC, 0);
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic do_reset();
    #2 clrn = 1'b0;
    #1;
    check("rst_rgb", rgb_out, 12'h000);
    check("rst_hit", hit_mask, 4'h0);
    check("rst_vld", rgb_valid, 1'b0);
    check("rst_coll", collision, 1'b0);
    check("rst_addr", rom_addr, 40'h0);
    @(negedge clk);
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
  endtask

  function automatic int rnd_coord();
    return ($urandom_range(0, 9) == 0) ? $urandom_range(1005, 1023) : $urandom_range(0, 79);
  endfunction

  function automatic logic [23:0] rnd_spr();
    int x;
    x = ($urandom_range(0, 7) == 0) ? $urandom_range(1010, 1023) : $urandom_range(0, 65);
    return spr($urandom_range(0, 5) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
               $urandom_range(0, 65), x);
  endfunction

  initial begin
    bit         we, pv;
    int         idx, f_exp;
    logic [23:0] wd;

    model_reset();
    fill_rom(0, 12'hf00); fill_rom(1, KEYC); fill_rom(2, 12'h0f0); fill_rom(3, KEYC);
    do_reset();

    // background only after reset
    for (int i = 0; i < 6; i++) cyc(1, 10 + i, 20, BGC, 0);

    // window edges; a mid-frame write stays in the shadow until frame start
    cyc(0, 0, 0, BGC, 0, 1, 0, spr(1, 0, 0, 100, 70));
    cyc(1, 70, 100, BGC, 0);
    cyc(1, 70, 100, BGC, 0);
    check("shadow_hold", rgb_out, BGC);
    frame_pulse();
    cyc(1, 70, 100, BGC, 0);
    cyc(1, 85, 115, BGC, 0);
    check("win_tl", rgb_out, 12'hf00);
    cyc(1, 69, 100, BGC, 0);
    check("win_br", rgb_out, 12'hf00);
    cyc(1, 86, 100, BGC, 0);
    check("win_left", rgb_out, BGC);
    cyc(1, 71, 101, BGC, 0);
    check("win_right", rgb_out, BGC);
    check("addr_71_101", rom_addr[AW-1:0], 10'd65);
    idle(2);

    // wrap-around at the right edge
    cyc(0, 0, 0, BGC, 0, 1, 2, spr(1, 0, 0, 0, 1015));
    frame_pulse();
    cyc(1, 3, 0, BGC, 0);
    cyc(1, 1015, 0, BGC, 0);
    check("wrap_bg", rgb_out, BGC);
    check("wrap_hit", hit_mask, 4'h0);
    cyc(1, 1020, 5, BGC, 0);
    check("wrap_in", rgb_out, 12'h0f0);
    idle(2);

    // priority and colour key
    cyc(0, 0, 0, BGC, 0, 1, 2, spr(0, 0, 0, 0, 0));
    cyc(0, 0, 0, BGC, 0, 1, 0, spr(1, 0, 0, 200, 200));
    cyc(0, 0, 0, BGC, 0, 1, 1, spr(1, 0, 0, 204, 204));
    fill_rom(0, KEYC); fill_rom(1, 12'h0ff);
    frame_pulse();
    cyc(1, 205, 205, BGC, 0);
    cyc(1, 0, 0, BGC, 0);
    check("prio_key_rgb", rgb_out, 12'h0ff);
    check("prio_key_hit", hit_mask, 4'b0010);
    idle(2);
    frame_pulse();
    check("no_coll", collision, 1'b0);
    fill_rom(0, 12'hfff);
    cyc(1, 205, 205, BGC, 0);
    cyc(1, 210, 210, BGC, 0);
    check("prio0_rgb", rgb_out, 12'hfff);
    check("prio0_hit", hit_mask, 4'b0011);
    idle(2);
    frame_pulse();
    check("coll_set", collision, 1'b1);
    idle(3);
    check("coll_hold", collision, 1'b1);
    frame_pulse();
    check("coll_clear", collision, 1'b0);

    // write-through: write and frame start in the same cycle
    cyc(0, 0, 0, BGC, 1, 1, 0, spr(1, 0, 0, 300, 300));
    cyc(1, 300, 300, BGC, 0);
    cyc(0, 0, 0, BGC, 0);
    check("wthru_rgb", rgb_out, 12'hfff);

    // animation sequencing from a clean counter
    do_reset();
    for (int a = 0; a < 1024; a++) rom_mem[3][a] = 12'h800 | 12'(a);
    fill_rom(2, 12'h0f0);
    cyc(0, 0, 0, BGC, 0, 1, 2, spr(1, 0, 3, 400, 400));
    cyc(0, 0, 0, BGC, 1, 1, 3, spr(1, 1, 3, 400, 400));
    for (int k = 1; k <= 24; k++) begin
      cyc(1, 401, 400, BGC, 0);
      f_exp = (3 + k / 8) % 4;
      check("anim_addr", rom_addr[3*AW +: AW], 10'(f_exp * 16 + 1));
      check("static_addr", rom_addr[2*AW +: AW], 10'd49);
      frame_pulse();
    end

    // randomized traffic
    for (int ch = 0; ch < N; ch++)
      for (int a = 0; a < 1024; a++)
        rom_mem[ch][a] = ($urandom_range(0, 2) == 0) ? KEYC : 12'($urandom);
    for (int fr = 0; fr < 30; fr++) begin
      if (fr == 15) begin
        cyc(1, 20, 20, BGC, 0);
        do_reset();
        for (int k = 0; k < 8; k++) cyc(1, $urandom_range(0, 79), $urandom_range(0, 79), BGC, 0);
      end
      we = $urandom_range(0, 1) == 1;
      idx = $urandom_range(0, N - 1);
      wd = rnd_spr();
      cyc(0, 0, 0, BGC, 1, we, idx, wd);
      for (int k = 0; k < 30; k++) begin
        we  = $urandom_range(0, 7) == 0;
        idx = $urandom_range(0, N - 1);
        wd  = rnd_spr();
        pv  = $urandom_range(0, 7) != 0;
        cyc(pv, rnd_coord(), rnd_coord(), 12'($urandom), 0, we, idx, wd);
      end
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
